// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch controller bus: redirect, instruction memory and decode handshake
// Purpose: bundles every non-clock signal of instr_fetch_ctrl. The master modport is the fetch
// controller. The slave modport is its environment: PC/branch logic, memory and decode.
// Ports:
//   redirect_i, redirect_pc_i    branch/jump redirect request and byte target address
//   imem_req_o, imem_addr_o      instruction memory read request and byte address
//   imem_rdata_i                 read data, valid the cycle after imem_req_o
//   instr_valid_o, instr_ready_i prefetch FIFO head handshake towards decode
//   instr_o, pc_o                head instruction and its byte PC (0 when empty)
//   fault_o                      sticky misaligned-redirect fault
//   imem_widx                    word index the memory decodes, imem_addr_o[ADDR_WIDTH+1:2]
interface instr_fetch_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  redirect_i;
  logic [DATA_WIDTH-1:0] redirect_pc_i;
  logic                  imem_req_o;
  logic [DATA_WIDTH-1:0] imem_addr_o;
  logic [DATA_WIDTH-1:0] imem_rdata_i;
  logic                  instr_valid_o;
  logic                  instr_ready_i;
  logic [DATA_WIDTH-1:0] instr_o;
  logic [DATA_WIDTH-1:0] pc_o;
  logic                  fault_o;
  logic [ADDR_WIDTH-1:0] imem_widx;

  assign imem_widx = imem_addr_o[ADDR_WIDTH+1:2];

  modport master (
    input  redirect_i, redirect_pc_i, imem_rdata_i, instr_ready_i,
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, fault_o
  );

  modport slave (
    output redirect_i, redirect_pc_i, imem_rdata_i, instr_ready_i,
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, fault_o, imem_widx
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - instruction fetch sequencer with prefetch FIFO and redirect handling
// Purpose: keeps the fetch PC and issues one word read per cycle to a 1-cycle-latency memory
// while credit allows. It buffers returned words with their PC and serves them to decode.
// A redirect flushes the buffer and drops the in-flight read. A misaligned redirect target
// locks the block in FAULT until rst.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  instr_fetch_if.master (redirect, imem request/data, decode handshake, fault)
module instr_fetch_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_epoch_q, inflight_epoch_d;
  logic [DATA_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                  epoch_q, epoch_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] fifo_instr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_pc_q    [FIFO_DEPTH];

  logic                  run;
  logic                  misaligned;
  logic                  flush;
  logic                  head_valid;
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [CW:0]           occupancy;
  logic [DATA_WIDTH-1:0] fetch_addr;

  assign run        = (state_q == S_RUN);
  assign misaligned = bus.redirect_i && (bus.redirect_pc_i[1:0] != 2'b00);
  assign flush      = run && bus.redirect_i;
  assign head_valid = run && (count_q != '0);
  assign pop        = head_valid && bus.instr_ready_i;
  // A response whose epoch tag is stale belongs to a redirected-away path.
  assign push       = run && inflight_q && (inflight_epoch_q == epoch_q);
  assign fetch_addr = bus.redirect_i ? bus.redirect_pc_i : fetch_pc_q;

  // Words already buffered plus the one on its way back, less the one leaving now.
  assign occupancy  = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);

  // A flushing redirect empties the FIFO and orphans the in-flight read, so it always has credit.
  assign issue = run && (bus.redirect_i ? !misaligned : (occupancy < (CW+1)'(FIFO_DEPTH)));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   if (misaligned) state_d = S_FAULT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_BOOT;
    endcase
  end

  // Outputs
  always_comb begin
    bus.imem_req_o    = issue;
    bus.imem_addr_o   = issue ? fetch_addr : '0;
    bus.instr_valid_o = head_valid;
    bus.instr_o       = head_valid ? fifo_instr_q[rd_ptr_q] : '0;
    bus.pc_o          = head_valid ? fifo_pc_q[rd_ptr_q] : '0;
    bus.fault_o       = (state_q == S_FAULT);
  end

  // Datapath next values
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (issue) begin
      fetch_pc_d = fetch_addr + DATA_WIDTH'(4);
    end else if (bus.redirect_i && (state_q != S_FAULT)) begin
      fetch_pc_d = bus.redirect_pc_i;
    end
    epoch_d          = flush ? ~epoch_q : epoch_q;
    inflight_d       = issue;
    inflight_epoch_d = epoch_d;
    inflight_pc_d    = issue ? fetch_addr : inflight_pc_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
      count_d  = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q       <= RESET_PC;
      inflight_q       <= 1'b0;
      inflight_epoch_q <= 1'b0;
      inflight_pc_q    <= '0;
      epoch_q          <= 1'b0;
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      count_q          <= '0;
    end else begin
      fetch_pc_q       <= fetch_pc_d;
      inflight_q       <= inflight_d;
      inflight_epoch_q <= inflight_epoch_d;
      inflight_pc_q    <= inflight_pc_d;
      epoch_q          <= epoch_d;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      count_q          <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= bus.imem_rdata_i;
      fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb/tb_instr_fetch_ctrl.sv - directed and randomized checks of instr_fetch_ctrl against a queue model
module tb_instr_fetch_ctrl;
  localparam int DW = 32;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst;

  instr_fetch_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  instr_fetch_ctrl #(
    .DATA_WIDTH(DW),
    .RESET_PC  (32'h0),
    .FIFO_DEPTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Memory: word i holds value i; garbage when no read was issued.
  always @(posedge clk) bus.imem_rdata_i <= bus.imem_req_o ? 32'(bus.imem_widx) : $urandom;

  int unsigned pass_cnt = 0;
  int unsigned fail_cnt = 0;
  int unsigned total_cnt = 0;

  // Reference model: buffered PCs, PC of the read issued last cycle, fetch pointer.
  bit          m_boot;
  bit          m_fault;
  logic [31:0] m_pc;
  logic [31:0] m_fifo[$];
  logic [31:0] m_pend[$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a >> 2) & 32'h0000_03FF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot  = 1'b1;
    m_fault = 1'b0;
    m_pc    = 32'h0;
    m_fifo.delete();
    m_pend.delete();
  endtask

  // Called at a negedge; asserts rst asynchronously mid-cycle and releases it at the next negedge.
  task automatic do_reset();
    bus.redirect_i    = 1'b0;
    bus.instr_ready_i = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("rst_req",   32'(bus.imem_req_o),    32'h0);
    check("rst_addr",  bus.imem_addr_o,        32'h0);
    check("rst_valid", 32'(bus.instr_valid_o), 32'h0);
    check("rst_instr", bus.instr_o,            32'h0);
    check("rst_pc",    bus.pc_o,               32'h0);
    check("rst_fault", 32'(bus.fault_o),       32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: drive at the negedge, check, let the edge pass, advance the model.
  task automatic cycle(input bit rd, input logic [31:0] rpc, input bit rdy);
    bit          e_valid;
    bit          e_req;
    bit          pop;
    logic [31:0] e_addr;
    logic [31:0] e_head;
    logic [31:0] a;
    bus.redirect_i    = rd;
    bus.redirect_pc_i = rpc;
    bus.instr_ready_i = rdy;
    #1;
    e_valid = !m_boot && !m_fault && (m_fifo.size() > 0);
    e_head  = e_valid ? m_fifo[0] : 32'h0;
    pop     = e_valid && rdy;
    e_addr  = rd ? rpc : m_pc;
    if (m_boot || m_fault) e_req = 1'b0;
    else if (rd)           e_req = (rpc[1:0] == 2'b00);
    else                   e_req = (m_fifo.size() + m_pend.size() - int'(pop)) < 2;
    check("instr_valid", 32'(bus.instr_valid_o), 32'(e_valid));
    check("pc",          bus.pc_o,               e_head);
    check("instr",       bus.instr_o,            e_valid ? word_of(e_head) : 32'h0);
    check("imem_req",    32'(bus.imem_req_o),    32'(e_req));
    if (e_req) check("imem_addr", bus.imem_addr_o, e_addr);
    check("fault",       32'(bus.fault_o),       32'(m_fault));
    @(posedge clk);
    if (m_boot) begin
      m_boot = 1'b0;
      if (rd) m_pc = rpc;
    end else if (!m_fault) begin
      if (rd && rpc[1:0] != 2'b00) begin
        m_fault = 1'b1;
        m_fifo.delete();
        m_pend.delete();
      end else begin
        if (pop) void'(m_fifo.pop_front());
        if (m_pend.size() > 0) begin
          a = m_pend.pop_front();
          if (!rd) m_fifo.push_back(a);
        end
        if (rd) m_fifo.delete();
        if (e_req) begin
          m_pend.push_back(e_addr);
          m_pc = e_addr + 32'd4;
        end else if (rd) begin
          m_pc = rpc;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int r;
    logic [31:0] t;
    rst               = 1'b1;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.instr_ready_i = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Streaming from reset: first valid at cycle 3 with pc 0, then one per cycle.
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1);
    check("first_valid", 32'(bus.instr_valid_o), 32'h1);
    check("first_pc",    bus.pc_o,               32'h0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1);

    // Decode stall for 5 cycles, then drain.
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b0);
    check("stall_no_req", 32'(bus.imem_req_o), 32'h0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1);

    // Redirect to 0x40 while 0x08 is in flight, in the same cycle pc 0x04 is popped.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1);
    check("pre_redirect_head", bus.pc_o, 32'h4);
    cycle(1'b1, 32'h40, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    check("redirect_target", bus.pc_o, 32'h40);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1);

    // Misaligned redirect: sticky fault until reset.
    cycle(1'b1, 32'h42, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, i[0]);

    // Fetch address wrap, then a reset pulse while reads are in flight.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b1, 32'hFFFF_FFFC, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1);
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      r = int'($urandom_range(0, 99));
      t = $urandom & 32'hFFFF_FFFC;
      if (r < 2) begin
        do_reset();
      end else begin
        if (r == 2) t[1:0] = 2'b10;
        cycle(r < 9, t, $urandom_range(0, 3) != 0);
        if (m_fault && $urandom_range(0, 7) == 0) do_reset();
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
